spi_frame_slave: RTL and testbench
==================================

Name: spi_frame_slave

Overview:
Parametrised SPI slave frontend for the SPI-to-MSX converter. It oversamples the external SPI pins in the system clk domain, supports all four CPOL/CPHA modes and MSB- or LSB-first bit order, and moves frames of FRAME_BITS bits. Each received frame is handed to the MSX bus sequencer through a valid/ready holding register. The transmit frame (MSX status word) is loaded at the start of every frame. Overrun and short-frame errors are reported.

Parameters:
FRAME_BITS, 40, bits per SPI frame (rx and tx); legal range 8..64
CPOL, 0, idle level of spi_sclk
CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge
MSB_FIRST, 1, 1 = bit FRAME_BITS-1 on the wire first; 0 = bit 0 first

Ports:
clk  in  1  system clock; must be at least 4x the spi_sclk frequency
nreset  in  1  asynchronous active-low reset
spi_cs_n  in  1  chip select, active low, asynchronous to clk
spi_sclk  in  1  SPI clock, asynchronous to clk
spi_mosi  in  1  SPI data in
spi_miso  out  1  SPI data out; 0 when spi_miso_oe=0
spi_miso_oe  out  1  pad output enable; 1 while a frame is selected
tx_data  in  FRAME_BITS  frame to transmit; sampled at each frame start
tx_ack  out  1  one-clk pulse when tx_data has been captured
rx_data  out  FRAME_BITS  last accepted frame
rx_valid  out  1  rx_data holds an unconsumed frame
rx_ready  in  1  consumer accepts rx_data when rx_valid & rx_ready
rx_overrun  out  1  one-clk pulse when a completed frame is dropped
short_frame  out  1  one-clk pulse when cs rises with a partial frame
frame_active  out  1  cs asserted and block armed

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on nreset. All flops clear on nreset=0.
- Reset values: spi_miso=0, spi_miso_oe=0, tx_ack=0, rx_data=0, rx_valid=0, rx_overrun=0, short_frame=0, frame_active=0. Bit counter=0, shift registers=0, armed=0.
- Synchronisers: spi_cs_n, spi_sclk and spi_mosi each pass through two flops. Edge detection uses a third flop on cs and sclk.
- Edge definitions: the leading edge is the transition away from CPOL; the trailing edge is the return to CPOL. The sample edge is the leading edge if CPHA=0, otherwise the trailing edge. The shift edge is the other edge.
- Arming: after reset, the block ignores the bus until synced cs has been seen high once (armed=1). This prevents joining a frame mid-stream.
- State machine:
  - IDLE -> ACTIVE on a synced cs falling edge while armed.
  - ACTIVE -> IDLE on a synced cs rising edge.
  - Reset returns the block to IDLE with armed=0.
- Frame start (entry to ACTIVE, and every wrap of the bit counter):
  - The tx shift register loads tx_data and tx_ack pulses.
  - If CPHA=0, the first tx bit drives spi_miso immediately.
  - If CPHA=1, the first tx bit drives spi_miso on the first shift edge.
- Sample edge: shift the synced mosi into the rx shift register in MSB_FIRST order, then bit_cnt+1.
- Shift edge: advance tx to the next bit. With CPHA=0, the first shift edge of a frame is the one after the first sample; it is never a pre-shift.
- Frame complete (bit_cnt reaches FRAME_BITS):
  - bit_cnt wraps to 0 and the next frame starts within the same cs.
  - If rx_valid=0, or rx_ready=1 in the same cycle, copy the assembled frame to rx_data and set rx_valid on the next clk edge.
  - Otherwise, drop the new frame, keep the old rx_data, and pulse rx_overrun.
- Handshake: rx_valid clears on the edge after rx_valid & rx_ready, unless a new frame is accepted in that same cycle (then it stays 1 with new data).
- Latency: rx_valid rises no more than 4 clk after the pin-level sample edge of the final bit.
- cs rising with bit_cnt != 0: pulse short_frame, discard the partial rx, reset bit_cnt. A cs rise with bit_cnt == 0 gives no pulse.
- spi_miso_oe equals frame_active; spi_miso is forced to 0 when inactive.
- Reset mid-frame: outputs go to reset values immediately; no rx_valid or short_frame is produced for the interrupted frame.

Optional Feature:
SPI_RX_BUFFER_EN: adds a second rx holding stage, making a 2-entry FIFO in front of rx_data/rx_valid.
- rx_overrun fires only when both entries are full.
- Frames are delivered in arrival order.
- Without the macro, the block has a single holding register as described above.

Decomposition:
- Package spi_frame_pkg: mode encoding constants (SPI_MODE0..3 as {CPOL,CPHA}) and a function computing the bit-counter width as $clog2(FRAME_BITS+1).
- One sub-module, spi_pin_sync: 2-flop synchroniser plus rise/fall edge detect, instantiated for cs, sclk and mosi.

Test Plan:
- Mode 0, FRAME_BITS=40, MSB first, send 40'h12_3456_789A, tx_data=40'hA5_0000_00FF -> rx_data=40'h12_3456_789A, rx_valid=1; bits captured on miso equal 40'hA5_0000_00FF; tx_ack pulses once.
- All four CPOL/CPHA combinations with MSB_FIRST=0, send 8'h01 (FRAME_BITS=8) -> rx_data=8'h01 in each mode; miso bit order matches the LSB-first encoding of tx_data.
- rx_ready held 0, two back-to-back 40-bit frames in one cs -> first frame retained, rx_overrun pulses exactly once, tx_ack pulses twice. With SPI_RX_BUFFER_EN: no overrun, and both frames are read in order.
- cs raised after 17 bits -> short_frame pulses once, rx_valid stays 0, the next full frame is received correctly.
- nreset asserted at bit 20 with cs held low, then released -> frame_active stays 0 until cs goes high then low; the following frame is received correctly.
- rx_ready=1 in the same cycle a new frame completes -> rx_valid stays 1, rx_data updates, no overrun.

Source files
------------

// File: rtl/spi_frame_pkg.sv
// Shared definitions for the SPI frame slave: SPI mode encodings, FSM states
// and the bit-counter width helper.
package spi_frame_pkg;

  // SPI modes encoded as {CPOL, CPHA}.
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } state_t;

  function automatic int cnt_width(input int frame_bits);
    return $clog2(frame_bits + 1);
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchroniser for one asynchronous SPI pin, plus a third flop that
// provides rise/fall strobes of the synchronised level.
module spi_pin_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [2:0] sync;

  // NOTE: sequential state uses non-blocking assignments so every flop in the
  // chain samples the value from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[1:0], pin};
    end
  end

  assign level = sync[1];
  assign rise  = sync[1] & ~sync[2];
  assign fall  = ~sync[1] & sync[2];

endmodule

// File: rtl/spi_frame_slave.sv
// SPI slave frontend: oversampled pins, all CPOL/CPHA modes, FRAME_BITS-bit
// frames, valid/ready rx hand-off. Define SPI_RX_BUFFER_EN for a 2-entry rx FIFO.
module spi_frame_slave
  import spi_frame_pkg::*;
#(
  parameter int unsigned FRAME_BITS = 40,
  parameter bit          CPOL       = 1'b0,
  parameter bit          CPHA       = 1'b0,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  spi_cs_n,
  input  logic                  spi_sclk,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  input  logic [FRAME_BITS-1:0] tx_data,
  output logic                  tx_ack,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  rx_overrun,
  output logic                  short_frame,
  output logic                  frame_active
);

  localparam int                CNT_W    = cnt_width(FRAME_BITS);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(FRAME_BITS - 1);
  localparam logic [1:0]        MODE     = {CPOL, CPHA};
  // Modes 0 and 3 sample on the rising sclk edge, modes 1 and 2 on the falling.
  localparam bit SAMPLE_ON_RISE = (MODE == SPI_MODE0) || (MODE == SPI_MODE3);

  logic cs_level, cs_rise, cs_fall;
  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic mosi_level;
  logic [1:0] mosi_edges_unused;

  spi_pin_sync u_cs_sync (
    .clk(clk), .rst_n(nreset), .pin(spi_cs_n),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  spi_pin_sync u_sclk_sync (
    .clk(clk), .rst_n(nreset), .pin(spi_sclk),
    .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_pin_sync u_mosi_sync (
    .clk(clk), .rst_n(nreset), .pin(spi_mosi),
    .level(mosi_level), .rise(mosi_edges_unused[0]), .fall(mosi_edges_unused[1])
  );

  function automatic logic head_bit(input logic [FRAME_BITS-1:0] w);
    return MSB_FIRST ? w[FRAME_BITS-1] : w[0];
  endfunction

  function automatic logic [FRAME_BITS-1:0] advance(input logic [FRAME_BITS-1:0] w);
    return MSB_FIRST ? {w[FRAME_BITS-2:0], 1'b0} : {1'b0, w[FRAME_BITS-1:1]};
  endfunction

  state_t                state;
  logic                  armed;
  logic [CNT_W-1:0]      bit_cnt;
  logic [FRAME_BITS-1:0] rx_shift;
  logic [FRAME_BITS-1:0] tx_shift;
  logic                  miso_r;

  logic                  sample_edge, shift_edge, tx_step, frame_done;
  logic [FRAME_BITS-1:0] rx_next, tx_load;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    sample_edge = SAMPLE_ON_RISE ? sclk_rise : sclk_fall;
    shift_edge  = SAMPLE_ON_RISE ? sclk_fall : sclk_rise;
    // With CPHA=0 the edge right after a frame wrap must not skip bit 0.
    tx_step     = shift_edge && (CPHA || (bit_cnt != '0));
    rx_next     = MSB_FIRST ? {rx_shift[FRAME_BITS-2:0], mosi_level}
                            : {mosi_level, rx_shift[FRAME_BITS-1:1]};
    tx_load     = CPHA ? tx_data : advance(tx_data);
    frame_done  = (state == ST_ACTIVE) && !cs_rise && sample_edge && (bit_cnt == LAST_BIT);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state       <= ST_IDLE;
      armed       <= 1'b0;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      miso_r      <= 1'b0;
      tx_ack      <= 1'b0;
      short_frame <= 1'b0;
    end else begin
      tx_ack      <= 1'b0;
      short_frame <= 1'b0;
      if (cs_level) armed <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (armed && cs_fall) begin
            state    <= ST_ACTIVE;
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= tx_load;
            tx_ack   <= 1'b1;
            if (!CPHA) miso_r <= head_bit(tx_data);
          end
        end
        ST_ACTIVE: begin
          if (cs_rise) begin
            state    <= ST_IDLE;
            miso_r   <= 1'b0;
            bit_cnt  <= '0;
            rx_shift <= '0;
            if (bit_cnt != '0) short_frame <= 1'b1;
          end else if (sample_edge) begin
            if (bit_cnt == LAST_BIT) begin
              bit_cnt  <= '0;
              rx_shift <= '0;
              tx_shift <= tx_load;
              tx_ack   <= 1'b1;
              if (!CPHA) miso_r <= head_bit(tx_data);
            end else begin
              bit_cnt  <= bit_cnt + 1'b1;
              rx_shift <= rx_next;
            end
          end else if (tx_step) begin
            miso_r   <= head_bit(tx_shift);
            tx_shift <= advance(tx_shift);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign frame_active = (state == ST_ACTIVE);
  assign spi_miso_oe  = frame_active;
  assign spi_miso     = miso_r;

`ifdef SPI_RX_BUFFER_EN
  logic [FRAME_BITS-1:0] buf_data;
  logic                  buf_valid;
  logic                  pop;

  assign pop = rx_valid && rx_ready;

  // NOTE: the holding data registers are reset too; they are a handful of
  // flops, not a RAM, so clearing them costs nothing and keeps rx_data defined.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      buf_data   <= '0;
      buf_valid  <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (pop) begin
        if (buf_valid) begin
          rx_data <= buf_data;
          if (frame_done) buf_data  <= rx_next;
          else            buf_valid <= 1'b0;
        end else if (frame_done) begin
          rx_data <= rx_next;
        end else begin
          rx_valid <= 1'b0;
        end
      end else if (frame_done) begin
        if (!rx_valid) begin
          rx_data  <= rx_next;
          rx_valid <= 1'b1;
        end else if (!buf_valid) begin
          buf_data  <= rx_next;
          buf_valid <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end
    end
  end
`else
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (frame_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= rx_next;
          rx_valid <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_spi_frame_slave.sv
// Directed bench: a 40-bit mode-0 MSB-first slave plus four 8-bit LSB-first
// slaves (one per SPI mode) sharing sclk/mosi, each with its own chip select.
module tb_spi_frame_slave;

  localparam int HP = 50;  // half sclk period = 5 clk

  logic clk, nreset, sclk, mosi;

  logic        cs_n0, miso0, oe0, tx_ack0, rx_valid0, rx_ready0, ovr0, short0, fa0;
  logic [39:0] tx_data0, rx_data0;

  logic [3:0] s_cs_n, s_miso, s_rx_valid;
  logic [3:0] s_oe_unused, s_ack_unused, s_ovr_unused, s_short_unused, s_fa_unused;
  logic [7:0] s_rx_data [4];

  int  n_checks = 0;
  int  n_fail   = 0;
  int  ack_cnt  = 0, ovr_cnt = 0, short_cnt = 0, drop_cnt = 0;
  int  ack_snap = 0;
  time last_edge_t = 0, rise_t = 0;

  spi_frame_slave #(.FRAME_BITS(40), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) u_dut (
    .clk(clk), .nreset(nreset), .spi_cs_n(cs_n0), .spi_sclk(sclk), .spi_mosi(mosi),
    .spi_miso(miso0), .spi_miso_oe(oe0), .tx_data(tx_data0), .tx_ack(tx_ack0),
    .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready0),
    .rx_overrun(ovr0), .short_frame(short0), .frame_active(fa0)
  );

  for (genvar m = 0; m < 4; m++) begin : g_mode
    spi_frame_slave #(.FRAME_BITS(8), .CPOL(1'((m >> 1) & 1)), .CPHA(1'(m & 1)),
                      .MSB_FIRST(1'b0)) u_small (
      .clk(clk), .nreset(nreset), .spi_cs_n(s_cs_n[m]), .spi_sclk(sclk), .spi_mosi(mosi),
      .spi_miso(s_miso[m]), .spi_miso_oe(s_oe_unused[m]), .tx_data(8'hB4),
      .tx_ack(s_ack_unused[m]), .rx_data(s_rx_data[m]), .rx_valid(s_rx_valid[m]),
      .rx_ready(1'b0), .rx_overrun(s_ovr_unused[m]), .short_frame(s_short_unused[m]),
      .frame_active(s_fa_unused[m])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    ack_cnt   += int'(tx_ack0);
    ovr_cnt   += int'(ovr0);
    short_cnt += int'(short0);
    drop_cnt  += int'(!rx_valid0);
  end

  always @(posedge rx_valid0) rise_t = $time;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic get_miso(input int dut);
    return (dut == 0) ? miso0 : s_miso[dut-1];
  endfunction

  task automatic set_cs(input int dut, input logic v);
    if (dut == 0) cs_n0 = v;
    else          s_cs_n[dut-1] = v;
  endtask

  task automatic select(input int dut, input bit cpol);
    sclk = cpol;
    #(2*HP);
    set_cs(dut, 1'b0);
    #(2*HP);
  endtask

  task automatic release_cs(input int dut);
    #HP;
    set_cs(dut, 1'b1);
    #(2*HP);
  endtask

  task automatic pop();
    @(negedge clk); rx_ready0 = 1'b1;
    @(negedge clk); rx_ready0 = 1'b0;
  endtask

  // Master side: clocks nbits of word out on mosi and reassembles miso.
  task automatic spi_bits(input int dut, input bit cpol, input bit cpha, input bit msb,
                          input int nbits, input logic [63:0] word, input bit ready_pulse,
                          output logic [63:0] got);
    int idx;
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      idx = msb ? nbits - 1 - i : i;
      if (cpha) sclk = ~cpol;
      mosi = word[idx];
      #HP;
      got[idx] = get_miso(dut);
      if (i == nbits - 1) begin
        ack_snap    = ack_cnt;
        last_edge_t = $time;
      end
      sclk = cpha ? cpol : ~cpol;
      if (ready_pulse && (i == nbits - 1)) begin
        #20; rx_ready0 = 1'b1;
        #10; rx_ready0 = 1'b0;
        #(HP - 30);
      end else begin
        #HP;
      end
      if (!cpha) sclk = cpol;
    end
  endtask

  logic [63:0] got;
  int ack_before, ovr_before, short_before, drop_before;

  initial begin
    nreset = 1'b0; sclk = 1'b0; mosi = 1'b0; rx_ready0 = 1'b0;
    cs_n0 = 1'b1; s_cs_n = 4'hF; tx_data0 = 40'hA5_0000_00FF;
    #50;
    check("reset_rx_valid", rx_valid0, 1'b0);
    check("reset_rx_data", rx_data0, 40'h0);
    check("reset_frame_active", fa0, 1'b0);
    check("reset_miso_oe", oe0, 1'b0);
    check("reset_miso", miso0, 1'b0);
    check("reset_pulses", {tx_ack0, ovr0, short0}, 3'b000);
    nreset = 1'b1;
    #50;

    // Single mode-0 frame, MSB first.
    ack_before = ack_cnt; short_before = short_cnt;
    select(0, 1'b0);
    check("t1_frame_active", {fa0, oe0}, 2'b11);
    spi_bits(0, 1'b0, 1'b0, 1'b1, 40, 64'h12_3456_789A, 1'b0, got);
    check("t1_latency_ok", (rise_t > last_edge_t) && (rise_t - last_edge_t <= 40), 1'b1);
    release_cs(0);
    check("t1_rx_data", rx_data0, 40'h12_3456_789A);
    check("t1_rx_valid", rx_valid0, 1'b1);
    check("t1_miso_word", got, 64'hA5_0000_00FF);
    check("t1_tx_ack_count", ack_snap - ack_before, 1);
    check("t1_no_short", short_cnt - short_before, 0);
    check("t1_idle_after_cs", {fa0, oe0, miso0}, 3'b000);
    pop();
    check("t1_consumed", rx_valid0, 1'b0);

    // Two back-to-back frames in one cs with rx_ready held low.
    ack_before = ack_cnt; ovr_before = ovr_cnt;
    select(0, 1'b0);
    spi_bits(0, 1'b0, 1'b0, 1'b1, 40, 64'h11_2233_4455, 1'b0, got);
    spi_bits(0, 1'b0, 1'b0, 1'b1, 40, 64'h66_7788_99AA, 1'b0, got);
    release_cs(0);
    check("t2_tx_ack_count", ack_snap - ack_before, 2);
    check("t2_first_kept", rx_data0, 40'h11_2233_4455);
    check("t2_rx_valid", rx_valid0, 1'b1);
`ifdef SPI_RX_BUFFER_EN
    check("t2_no_overrun", ovr_cnt - ovr_before, 0);
    pop();
    check("t2_second_data", rx_data0, 40'h66_7788_99AA);
    check("t2_second_valid", rx_valid0, 1'b1);
`else
    check("t2_overrun_once", ovr_cnt - ovr_before, 1);
`endif
    pop();
    check("t2_drained", rx_valid0, 1'b0);

    // Short frame of 17 bits, then a full frame.
    short_before = short_cnt;
    tx_data0 = 40'h01_2345_6789;
    select(0, 1'b0);
    spi_bits(0, 1'b0, 1'b0, 1'b1, 17, 64'h1_5555, 1'b0, got);
    release_cs(0);
    check("t3_short_once", short_cnt - short_before, 1);
    check("t3_no_valid", rx_valid0, 1'b0);
    select(0, 1'b0);
    spi_bits(0, 1'b0, 1'b0, 1'b1, 40, 64'hDE_ADBE_EF01, 1'b0, got);
    release_cs(0);
    check("t3_rx_data", rx_data0, 40'hDE_ADBE_EF01);
    check("t3_miso_word", got, 64'h01_2345_6789);
    pop();

    // Reset at bit 20 with cs held low.
    short_before = short_cnt;
    select(0, 1'b0);
    spi_bits(0, 1'b0, 1'b0, 1'b1, 20, 64'hF_0F0F, 1'b0, got);
    nreset = 1'b0;
    #20;
    check("t4_reset_outputs", {fa0, oe0, miso0, rx_valid0}, 4'b0000);
    #30;
    nreset = 1'b1;
    #20;
    spi_bits(0, 1'b0, 1'b0, 1'b1, 20, 64'hA_AAAA, 1'b0, got);
    check("t4_not_rearmed", fa0, 1'b0);
    release_cs(0);
    check("t4_no_valid", rx_valid0, 1'b0);
    check("t4_no_short", short_cnt - short_before, 0);
    select(0, 1'b0);
    check("t4_rearmed", fa0, 1'b1);
    spi_bits(0, 1'b0, 1'b0, 1'b1, 40, 64'h0F_1E2D_3C4B, 1'b0, got);
    release_cs(0);
    check("t4_rx_data", rx_data0, 40'h0F_1E2D_3C4B);
    check("t4_miso_word", got, 64'h01_2345_6789);
    pop();

    // rx_ready in the same cycle a new frame completes.
    select(0, 1'b0);
    spi_bits(0, 1'b0, 1'b0, 1'b1, 40, 64'hAA_BBCC_DDEE, 1'b0, got);
    release_cs(0);
    ovr_before = ovr_cnt; drop_before = drop_cnt;
    select(0, 1'b0);
    spi_bits(0, 1'b0, 1'b0, 1'b1, 40, 64'h55_6677_8899, 1'b1, got);
    release_cs(0);
    check("t5_rx_data", rx_data0, 40'h55_6677_8899);
    check("t5_rx_valid", rx_valid0, 1'b1);
    check("t5_no_overrun", ovr_cnt - ovr_before, 0);
    check("t5_valid_held", drop_cnt - drop_before, 0);
    pop();

    // All four modes, 8-bit LSB-first, tx_data = 8'hB4.
    for (int m = 0; m < 4; m++) begin
      select(m + 1, 1'((m >> 1) & 1));
      spi_bits(m + 1, 1'((m >> 1) & 1), 1'(m & 1), 1'b0, 8, 64'h01, 1'b0, got);
      release_cs(m + 1);
      check($sformatf("mode%0d_rx_data", m), s_rx_data[m], 8'h01);
      check($sformatf("mode%0d_rx_valid", m), s_rx_valid[m], 1'b1);
      check($sformatf("mode%0d_miso_word", m), got, 64'hB4);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
